johnson_seq_monitor: RTL and testbench



---
 rtl/johnson_seq_monitor.sv | 164 ++++++++++++++++
 tb/tb_johnson_seq_monitor.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/johnson_seq_monitor.sv
// Johnson-code sequence monitor: decodes 4-stage Johnson codes, classifies
// each step, tracks lock to a clean sequence and counts errors while locked.
module johnson_seq_monitor #(
    parameter int LOCK_N = 4,
    parameter int ERR_W  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       code_i,
    input  logic             code_valid_i,
    output logic [2:0]       index_o,
    output logic             index_valid_o,
    output logic             step_up_o,
    output logic             step_down_o,
    output logic             step_hold_o,
    output logic             err_illegal_o,
    output logic             err_skip_o,
    output logic             locked_o,
    output logic [ERR_W-1:0] err_count_o
);

    localparam logic [0:0] ST_UNLOCKED = 1'b0;
    localparam logic [0:0] ST_LOCKED   = 1'b1;
    localparam logic [3:0] LOCK_C      = 4'(LOCK_N);

    logic [0:0]       state_q, state_d;
    logic [2:0]       index_q, index_d;
    logic             have_prev_q, have_prev_d;
    logic [3:0]       good_q, good_d;
    logic             last_err_q, last_err_d;
    logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
    logic             iv_q, iv_d;
    logic             up_q, up_d;
    logic             dn_q, dn_d;
    logic             hd_q, hd_d;
    logic             il_q, il_d;
    logic             sk_q, sk_d;

    logic       legal;
    logic [2:0] dec_idx;
    logic [2:0] delta;
    logic       is_up, is_dn, is_hd, is_sk, is_err, is_good;

    always_comb begin
        legal   = 1'b1;
        dec_idx = 3'd0;
        unique case (code_i)
            4'b0000: dec_idx = 3'd0;
            4'b0001: dec_idx = 3'd1;
            4'b0011: dec_idx = 3'd2;
            4'b0111: dec_idx = 3'd3;
            4'b1111: dec_idx = 3'd4;
            4'b1110: dec_idx = 3'd5;
            4'b1100: dec_idx = 3'd6;
            4'b1000: dec_idx = 3'd7;
            default: legal   = 1'b0;
        endcase
    end

    // index_q doubles as the previous-legal-index register
    assign delta   = dec_idx - index_q;
    assign is_up   = legal && have_prev_q && (delta == 3'd1);
    assign is_dn   = legal && have_prev_q && (delta == 3'd7);
    assign is_hd   = legal && have_prev_q && (delta == 3'd0);
    assign is_sk   = legal && have_prev_q && !(is_up || is_dn || is_hd);
    assign is_err  = !legal || is_sk;
    assign is_good = is_up || is_dn || is_hd;

    always_comb begin
        state_d     = state_q;
        index_d     = index_q;
        have_prev_d = have_prev_q;
        good_d      = good_q;
        last_err_d  = last_err_q;
        err_cnt_d   = err_cnt_q;
        iv_d        = 1'b0;
        up_d        = 1'b0;
        dn_d        = 1'b0;
        hd_d        = 1'b0;
        il_d        = 1'b0;
        sk_d        = 1'b0;
        if (code_valid_i) begin
            iv_d = 1'b1;
            up_d = is_up;
            dn_d = is_dn;
            hd_d = is_hd;
            il_d = !legal;
            sk_d = is_sk;
            if (legal) begin
                index_d     = dec_idx;
                have_prev_d = 1'b1;
            end
            if (state_q == ST_UNLOCKED) begin
                if (is_err) begin
                    good_d = 4'd0;
                end else if (is_good) begin
                    if (good_q + 4'd1 >= LOCK_C) begin
                        state_d    = ST_LOCKED;
                        good_d     = 4'd0;
                        last_err_d = 1'b0;
                    end else begin
                        good_d = good_q + 4'd1;
                    end
                end
            end else begin
                if (is_err) begin
                    if (err_cnt_q != '1) begin
                        err_cnt_d = err_cnt_q + ERR_W'(1);
                    end
                    if (last_err_q) begin
                        state_d    = ST_UNLOCKED;
                        good_d     = 4'd0;
                        last_err_d = 1'b0;
                    end else begin
                        last_err_d = 1'b1;
                    end
                end else if (is_good) begin
                    last_err_d = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_UNLOCKED;
            index_q     <= 3'd0;
            have_prev_q <= 1'b0;
            good_q      <= 4'd0;
            last_err_q  <= 1'b0;
            err_cnt_q   <= '0;
            iv_q        <= 1'b0;
            up_q        <= 1'b0;
            dn_q        <= 1'b0;
            hd_q        <= 1'b0;
            il_q        <= 1'b0;
            sk_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            index_q     <= index_d;
            have_prev_q <= have_prev_d;
            good_q      <= good_d;
            last_err_q  <= last_err_d;
            err_cnt_q   <= err_cnt_d;
            iv_q        <= iv_d;
            up_q        <= up_d;
            dn_q        <= dn_d;
            hd_q        <= hd_d;
            il_q        <= il_d;
            sk_q        <= sk_d;
        end
    end

    assign index_o       = index_q;
    assign index_valid_o = iv_q;
    assign step_up_o     = up_q;
    assign step_down_o   = dn_q;
    assign step_hold_o   = hd_q;
    assign err_illegal_o = il_q;
    assign err_skip_o    = sk_q;
    assign locked_o      = (state_q == ST_LOCKED);
    assign err_count_o   = err_cnt_q;

endmodule

// File: tb/tb_johnson_seq_monitor.sv
// Directed bench for johnson_seq_monitor: default instance plus an ERR_W=2
// instance sharing the same stimulus to exercise error-counter saturation.
module tb_johnson_seq_monitor;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] code;
    logic       code_valid;

    logic [2:0] idx_a, idx_b;
    logic       iv_a, up_a, dn_a, hd_a, il_a, sk_a, lk_a;
    logic       iv_b, up_b, dn_b, hd_b, il_b, sk_b, lk_b;
    logic [7:0] ec_a;
    logic [1:0] ec_b;

    int n_chk  = 0;
    int n_fail = 0;

    localparam logic [4:0] F_NO = 5'b00000;
    localparam logic [4:0] F_UP = 5'b10000;
    localparam logic [4:0] F_DN = 5'b01000;
    localparam logic [4:0] F_HD = 5'b00100;
    localparam logic [4:0] F_IL = 5'b00010;
    localparam logic [4:0] F_SK = 5'b00001;

    always #5 clk = ~clk;

    johnson_seq_monitor u_a (
        .clk(clk), .rst(rst), .code_i(code), .code_valid_i(code_valid),
        .index_o(idx_a), .index_valid_o(iv_a), .step_up_o(up_a),
        .step_down_o(dn_a), .step_hold_o(hd_a), .err_illegal_o(il_a),
        .err_skip_o(sk_a), .locked_o(lk_a), .err_count_o(ec_a)
    );

    johnson_seq_monitor #(.LOCK_N(4), .ERR_W(2)) u_b (
        .clk(clk), .rst(rst), .code_i(code), .code_valid_i(code_valid),
        .index_o(idx_b), .index_valid_o(iv_b), .step_up_o(up_b),
        .step_down_o(dn_b), .step_hold_o(hd_b), .err_illegal_o(il_b),
        .err_skip_o(sk_b), .locked_o(lk_b), .err_count_o(ec_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // status vector = {index, index_valid, up, down, hold, illegal, skip, locked}
    task automatic ex(input string tag, input int idx, input logic [4:0] flg,
                      input logic iv, input logic lk, input int ec);
        logic [9:0] exp_v;
        int         ec2;
        exp_v = {3'(idx), iv, flg, lk};
        ec2   = (ec > 3) ? 3 : ec;
        chk({tag, ".a"}, 32'({idx_a, iv_a, up_a, dn_a, hd_a, il_a, sk_a, lk_a}),
            32'(exp_v));
        chk({tag, ".ec8"}, 32'(ec_a), 32'(ec));
        chk({tag, ".b"}, 32'({idx_b, iv_b, up_b, dn_b, hd_b, il_b, sk_b, lk_b}),
            32'(exp_v));
        chk({tag, ".ec2"}, 32'(ec_b), 32'(ec2));
    endtask

    task automatic drv(input logic [3:0] c, input logic v);
        code       = c;
        code_valid = v;
        @(negedge clk);
    endtask

    initial begin
        rst        = 1'b1;
        code       = 4'b0000;
        code_valid = 1'b0;
        repeat (2) @(negedge clk);
        ex("reset", 0, F_NO, 1'b0, 1'b0, 0);
        rst = 1'b0;

        drv(4'b0000, 1'b1); ex("t1_first", 0, F_NO, 1, 0, 0);
        drv(4'b0001, 1'b1); ex("t1_up1", 1, F_UP, 1, 0, 0);
        drv(4'b0011, 1'b1); ex("t1_up2", 2, F_UP, 1, 0, 0);
        drv(4'b0111, 1'b1); ex("t1_up3", 3, F_UP, 1, 0, 0);
        drv(4'b1111, 1'b1); ex("t1_lock", 4, F_UP, 1, 1, 0);

        drv(4'b1110, 1'b1); ex("t2_up5", 5, F_UP, 1, 1, 0);
        drv(4'b1100, 1'b1); ex("t2_up6", 6, F_UP, 1, 1, 0);
        drv(4'b1000, 1'b1); ex("t2_up7", 7, F_UP, 1, 1, 0);
        drv(4'b0000, 1'b1); ex("t2_wrap_up", 0, F_UP, 1, 1, 0);
        drv(4'b0001, 1'b1); ex("t2_up1", 1, F_UP, 1, 1, 0);
        drv(4'b0001, 1'b1); ex("t2_hold", 1, F_HD, 1, 1, 0);
        drv(4'b1010, 1'b0); ex("t2_novalid", 1, F_NO, 0, 1, 0);
        drv(4'b0011, 1'b1); ex("t2_up2", 2, F_UP, 1, 1, 0);
        drv(4'b0111, 1'b1); ex("t2_up3", 3, F_UP, 1, 1, 0);

        drv(4'b0011, 1'b1); ex("t3_dn2", 2, F_DN, 1, 1, 0);
        drv(4'b0001, 1'b1); ex("t3_dn1", 1, F_DN, 1, 1, 0);
        drv(4'b0000, 1'b1); ex("t3_dn0", 0, F_DN, 1, 1, 0);
        drv(4'b1000, 1'b1); ex("t3_wrap_dn", 7, F_DN, 1, 1, 0);
        drv(4'b0000, 1'b1); ex("t3_dir_up0", 0, F_UP, 1, 1, 0);
        drv(4'b0001, 1'b1); ex("t3_up1", 1, F_UP, 1, 1, 0);
        drv(4'b0011, 1'b1); ex("t3_up2", 2, F_UP, 1, 1, 0);
        drv(4'b0111, 1'b1); ex("t3_up3", 3, F_UP, 1, 1, 0);

        drv(4'b0101, 1'b1); ex("t4_illegal", 3, F_IL, 1, 1, 1);
        drv(4'b1111, 1'b1); ex("t4_up4", 4, F_UP, 1, 1, 1);

        drv(4'b0111, 1'b1); ex("t5_dn3", 3, F_DN, 1, 1, 1);
        drv(4'b0011, 1'b1); ex("t5_dn2", 2, F_DN, 1, 1, 1);
        drv(4'b0001, 1'b1); ex("t5_dn1", 1, F_DN, 1, 1, 1);
        drv(4'b0111, 1'b1); ex("t5_skip", 3, F_SK, 1, 1, 2);
        drv(4'b1010, 1'b1); ex("t5_unlock", 3, F_IL, 1, 0, 3);
        drv(4'b0110, 1'b1); ex("t5_ul_illegal", 3, F_IL, 1, 0, 3);
        drv(4'b1111, 1'b1); ex("t5_rl1", 4, F_UP, 1, 0, 3);
        drv(4'b1110, 1'b1); ex("t5_rl2", 5, F_UP, 1, 0, 3);
        drv(4'b1100, 1'b1); ex("t5_rl3", 6, F_UP, 1, 0, 3);
        drv(4'b1000, 1'b1); ex("t5_relock", 7, F_UP, 1, 1, 3);

        drv(4'b0101, 1'b1); ex("t6_e1", 7, F_IL, 1, 1, 4);
        drv(4'b0000, 1'b1); ex("t6_g1", 0, F_UP, 1, 1, 4);
        drv(4'b1111, 1'b1); ex("t6_e2", 4, F_SK, 1, 1, 5);
        drv(4'b1110, 1'b1); ex("t6_g2", 5, F_UP, 1, 1, 5);
        drv(4'b1001, 1'b1); ex("t6_e3", 5, F_IL, 1, 1, 6);
        drv(4'b1100, 1'b1); ex("t6_g3", 6, F_UP, 1, 1, 6);
        drv(4'b0011, 1'b1); ex("t6_e4", 2, F_SK, 1, 1, 7);
        drv(4'b0111, 1'b1); ex("t6_g4", 3, F_UP, 1, 1, 7);
        drv(4'b1011, 1'b1); ex("t6_e5", 3, F_IL, 1, 1, 8);
        drv(4'b1111, 1'b1); ex("t6_g5", 4, F_UP, 1, 1, 8);
        drv(4'b0100, 1'b1); ex("t6_gap_e1", 4, F_IL, 1, 1, 9);
        drv(4'b0000, 1'b0); ex("t6_gap", 4, F_NO, 0, 1, 9);
        drv(4'b1101, 1'b1); ex("t6_gap_e2", 4, F_IL, 1, 0, 10);

        rst = 1'b1;
        drv(4'b0001, 1'b1); ex("t6_rst", 0, F_NO, 0, 0, 0);
        rst = 1'b0;
        drv(4'b1111, 1'b1); ex("t6_post_first", 4, F_NO, 1, 0, 0);
        drv(4'b1110, 1'b1); ex("t6_post_up", 5, F_UP, 1, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
